// File: rtl/serial_divider.sv
// rtl/serial_divider.sv - multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
//
// Ports:
//   clk             clock, all state updates on the rising edge
//   rst             asynchronous active-low reset
//   div_in_rdata1   dividend (rs1)
//   div_in_rdata2   divisor (rs2)
//   div_in_enable   one-cycle start pulse; also aborts and restarts a division in flight
//   div_in_op       00 DIV, 01 DIVU, 10 REM, 11 REMU
//   div_out_ready   one-cycle completion pulse (registered)
//   div_out_result  quotient or remainder, held until the next completion (registered)
//
// Build option: define DIV_EARLY_EXIT_EN to iterate only over the significant
// bits of |dividend|. Results are identical; only latency changes.

module serial_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] div_in_rdata1,
  input  logic [XLEN-1:0] div_in_rdata2,
  input  logic            div_in_enable,
  input  logic [1:0]      div_in_op,
  output logic            div_out_ready,
  output logic [XLEN-1:0] div_out_result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_q, state_d;

  // Datapath registers. dvd_q starts as |a| and, as it shifts left, collects
  // quotient bits at the LSB, so after the last iteration it holds the quotient.
  logic            op_rem_q, op_rem_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ready_d;
  logic [XLEN-1:0] result_d;

  // Entry decode of the incoming operands
  logic            is_signed;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            b_zero, ovf, fast;
  logic [XLEN-1:0] fast_result;
  logic [XLEN-1:0] dvd_init;
  logic [CW-1:0]   cnt_init;

`ifdef DIV_EARLY_EXIT_EN
  logic [CW-1:0]   a_len;
  logic            a_zero;

  always_comb begin
    a_len = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (abs_a[i]) a_len = CW'(i + 1);
    end
  end
`endif

  always_comb begin
    is_signed = ~div_in_op[0];
    abs_a     = (is_signed && div_in_rdata1[XLEN-1]) ? -div_in_rdata1 : div_in_rdata1;
    abs_b     = (is_signed && div_in_rdata2[XLEN-1]) ? -div_in_rdata2 : div_in_rdata2;
    b_zero    = (div_in_rdata2 == '0);
    ovf       = is_signed && (div_in_rdata1 == INT_MIN) && (div_in_rdata2 == '1);
`ifdef DIV_EARLY_EXIT_EN
    // Align the top set bit of |a| to the MSB so only a_len iterations are needed.
    a_zero      = (abs_a == '0);
    fast        = b_zero || ovf || a_zero;
    dvd_init    = abs_a << (CW'(XLEN) - a_len);
    cnt_init    = a_len;
`else
    fast        = b_zero || ovf;
    dvd_init    = abs_a;
    cnt_init    = CW'(XLEN);
`endif
    // b=0 has priority: quotient all ones, remainder is the raw dividend.
    // Any other fast case (overflow, or zero dividend) yields remainder 0.
    if (b_zero) begin
      fast_result = div_in_op[1] ? div_in_rdata1 : '1;
    end else if (ovf) begin
      fast_result = div_in_op[1] ? '0 : INT_MIN;
    end else begin
      fast_result = '0;
    end
  end

  // One restoring iteration. When rem_sh >= divisor the true difference is
  // below 2^XLEN, so the XLEN-bit modular subtraction is exact.
  logic [XLEN:0]   rem_sh;
  logic            ge;
  logic [XLEN-1:0] rem_sub, rem_nx, quo_nx;
  logic [XLEN-1:0] q_fin, r_fin;
  logic            last;

  always_comb begin
    rem_sh  = {rem_q, dvd_q[XLEN-1]};
    ge      = (rem_sh >= {1'b0, dsr_q});
    rem_sub = rem_sh[XLEN-1:0] - dsr_q;
    rem_nx  = ge ? rem_sub : rem_sh[XLEN-1:0];
    quo_nx  = {dvd_q[XLEN-2:0], ge};
    q_fin   = neg_q_q ? -quo_nx : quo_nx;
    r_fin   = neg_r_q ? -rem_nx : rem_nx;
    last    = (cnt_q == CW'(1));
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; a start request wins in every state (abort/restart).
  always_comb begin
    state_d = state_q;
    if (div_in_enable) begin
      state_d = fast ? DONE : BUSY;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        BUSY:    state_d = last ? DONE : BUSY;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output/datapath next values
  always_comb begin
    op_rem_d = op_rem_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    result_d = div_out_result;
    if (div_in_enable) begin
      op_rem_d = div_in_op[1];
      neg_q_d  = is_signed && (div_in_rdata1[XLEN-1] ^ div_in_rdata2[XLEN-1]);
      neg_r_d  = is_signed && div_in_rdata1[XLEN-1];
      dvd_d    = dvd_init;
      dsr_d    = abs_b;
      rem_d    = '0;
      cnt_d    = fast ? '0 : cnt_init;
      if (fast) begin
        ready_d  = 1'b1;
        result_d = fast_result;
      end
    end else if (state_q == BUSY) begin
      dvd_d = quo_nx;
      rem_d = rem_nx;
      cnt_d = cnt_q - CW'(1);
      if (last) begin
        ready_d  = 1'b1;
        result_d = op_rem_q ? r_fin : q_fin;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_rem_q       <= 1'b0;
      neg_q_q        <= 1'b0;
      neg_r_q        <= 1'b0;
      dvd_q          <= '0;
      dsr_q          <= '0;
      rem_q          <= '0;
      cnt_q          <= '0;
      div_out_ready  <= 1'b0;
      div_out_result <= '0;
    end else begin
      op_rem_q       <= op_rem_d;
      neg_q_q        <= neg_q_d;
      neg_r_q        <= neg_r_d;
      dvd_q          <= dvd_d;
      dsr_q          <= dsr_d;
      rem_q          <= rem_d;
      cnt_q          <= cnt_d;
      div_out_ready  <= ready_d;
      div_out_result <= result_d;
    end
  end

endmodule

// File: tb/tb_serial_divider.sv
// tb/tb_serial_divider.sv - self-checking bench for serial_divider

module tb_serial_divider;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rdata1, rdata2;
  logic        enable;
  logic [1:0]  op;
  logic        ready;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_divider #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .div_in_rdata1  (rdata1),
    .div_in_rdata2  (rdata2),
    .div_in_enable  (enable),
    .div_in_op      (op),
    .div_out_ready  (ready),
    .div_out_result (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RV32M semantics with plain arithmetic (SV division truncates toward zero).
  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  // Cycle (counted from the enable cycle = 0) in which ready is expected.
  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_EXIT_EN
    begin
      longint mag;
      mag = (!o[0] && a[31]) ? -longint'($signed(a)) : longint'({32'd0, a});
      if (mag == 0) return 1;
      return $clog2(mag + 1) + 1;
    end
`else
    return 33;
`endif
  endfunction

  function automatic logic [31:0] rnd_operand(input bit allow_zero);
    case ($urandom_range(0, 7))
      0:       return allow_zero ? 32'd0 : 32'd1;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 15));
      4:       return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    rdata1 = a;
    rdata2 = b;
    op     = o;
    enable = 1'b1;
  endtask

  task automatic run_div(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int          cyc;
    int          exp_l;
    logic [31:0] exp_r;
    exp_r = ref_result(o, a, b);
    exp_l = ref_latency(o, a, b);
    @(negedge clk);
    check({tag, ".idle_ready"}, {31'd0, ready}, 32'd0);
    start(o, a, b);
    @(negedge clk);
    enable = 1'b0;
    rdata1 = $urandom;
    rdata2 = $urandom;
    cyc = 1;
    while (!ready && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, 32'(cyc), 32'(exp_l));
    if (!ready) return;
    check({tag, ".result"}, result, exp_r);
    @(negedge clk);
    check({tag, ".pulse"}, {31'd0, ready}, 32'd0);
    check({tag, ".hold"}, result, exp_r);
  endtask

  initial begin
    int          cyc;
    int          lat1, cut;
    bit          early;
    logic [1:0]  o;
    logic [31:0] a, b;

    rst    = 1'b0;
    enable = 1'b0;
    op     = 2'b00;
    rdata1 = 32'd0;
    rdata2 = 32'd0;
    repeat (2) @(negedge clk);
    check("reset.ready", {31'd0, ready}, 32'd0);
    check("reset.result", result, 32'd0);
    rst = 1'b1;

    run_div("div_neg",   OP_DIV,  32'hFFFF_FFEC, 32'd3);
    run_div("rem_neg",   OP_REM,  32'hFFFF_FFEC, 32'd3);
    run_div("divu_by0",  OP_DIVU, 32'h1234_5678, 32'd0);
    run_div("remu_by0",  OP_REMU, 32'h1234_5678, 32'd0);
    run_div("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    run_div("rem_ovf",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF);
    run_div("divu_5_2",  OP_DIVU, 32'd5, 32'd2);
    run_div("remu_5_2",  OP_REMU, 32'd5, 32'd2);
    run_div("div_zero",  OP_DIV,  32'd0, 32'd5);
    run_div("rem_by0",   OP_REM,  32'hFFFF_FFF0, 32'd0);
    run_div("divu_max",  OP_DIVU, 32'hFFFF_FFFF, 32'd1);
    run_div("div_min_2", OP_DIV,  32'h8000_0000, 32'd2);

    for (int i = 0; i < 50; i++) begin
      o = 2'($urandom_range(0, 3));
      a = rnd_operand(1'b1);
      b = ($urandom_range(0, 9) == 0) ? 32'd0 : rnd_operand(1'b0);
      run_div($sformatf("rand%0d", i), o, a, b);
    end

    // Abort: a second enable mid-flight restarts; the first never completes.
    lat1 = ref_latency(OP_DIVU, 32'd100, 32'd7);
    cut  = (lat1 > 10) ? 10 : lat1 - 1;
    @(negedge clk);
    start(OP_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    enable = 1'b0;
    early  = 1'b0;
    cyc    = 1;
    while (cyc < cut) begin
      if (ready) early = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (ready) early = 1'b1;
    check("abort.no_first_ready", {31'd0, early}, 32'd0);
    start(OP_DIVU, 32'd9, 32'd4);
    @(negedge clk);
    enable = 1'b0;
    cyc    = cut + 1;
    while (!ready && cyc < 150) begin
      @(negedge clk);
      cyc++;
    end
    check("abort.latency", 32'(cyc), 32'(cut + ref_latency(OP_DIVU, 32'd9, 32'd4)));
    check("abort.result", result, 32'd2);
    @(negedge clk);

    // Reset during BUSY clears outputs at once and nothing completes afterwards.
    lat1 = ref_latency(OP_DIVU, 32'd1000, 32'd3);
    cut  = (lat1 > 15) ? 15 : lat1 - 1;
    start(OP_DIVU, 32'd1000, 32'd3);
    @(negedge clk);
    enable = 1'b0;
    repeat (cut - 1) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.ready", {31'd0, ready}, 32'd0);
    check("rst.result", result, 32'd0);
    @(negedge clk);
    rst   = 1'b1;
    early = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready) early = 1'b1;
    end
    check("rst.no_ready", {31'd0, early}, 32'd0);
    run_div("post_rst", OP_DIVU, 32'd6, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
